ifu: RTL and testbench
======================

# ifu

Instruction fetch unit. It owns the architectural program counter, fetches the instruction at that address from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. Its `iaddr` output drives `npc`. The `niaddr` that `npc` returns is committed to the program counter when decode accepts the held instruction. The unit also detects misaligned next addresses and instruction-memory timeouts, and counts retired instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: program counter value loaded on reset.
- `TIMEOUT`, default 16: maximum number of consecutive `imem_req` cycles without `imem_ack` before a fault. Legal range is 2..255.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `iaddr`, output, 32: current PC, i.e. the address of the instruction being fetched or held. Goes to `npc`.
- `niaddr`, input, 32: next PC from `npc`. Sampled only on a consume edge.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address. Always equals `iaddr`.
- `imem_ack`, input, 1: memory response. `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: instruction word.
- `inst_valid`, output, 1: `inst` holds a fetched instruction.
- `inst`, output, 32: held instruction word.
- `inst_ready`, input, 1: decode accepts `inst`.
- `fault`, output, 1: sticky fault flag.
- `fault_code`, output, 2: 2'b01 means misaligned `niaddr`; 2'b10 means fetch timeout; 2'b00 means no fault.
- `retired`, output, 32: number of consumed instructions. Wraps modulo 2^32.

## Operation
The state machine has four states: IDLE, FETCH, HOLD and FAULT.

IDLE
- Entered on reset.
- Moves to FETCH unconditionally on the first edge with `rst_n` high.

FETCH
- `imem_req` = 1 and `imem_addr` = PC.
- On an edge where `imem_ack` = 1: `inst` <= `imem_rdata`, the timeout counter clears, and the state moves to HOLD.
- On an edge where `imem_ack` = 0: the timeout counter increments. If the counter was already TIMEOUT-1, the state moves to FAULT with `fault_code` = 2'b10.
- If `imem_ack` = 1 on the TIMEOUT-th cycle, the ack wins and the state moves to HOLD.

HOLD
- `inst_valid` = 1 and `imem_req` = 0.
- A consume edge is an edge where `inst_valid` and `inst_ready` are both 1.
- On a consume edge with `niaddr[1:0]` == 0: PC <= `niaddr`, `retired` increments, and the state moves to FETCH.
- On a consume edge with `niaddr[1:0]` != 0: PC stays unchanged, `retired` still increments, and the state moves to FAULT with `fault_code` = 2'b01.
- `inst` is stable while `inst_ready` is low.

FAULT
- `fault` = 1, `imem_req` = 0, `inst_valid` = 0.
- `fault_code` holds its value. `iaddr` holds the PC of the faulting fetch, or of the instruction whose successor was misaligned.
- The only exit is reset.

Combinational outputs:
- `imem_req` is decoded from the state.
- `inst_valid` is decoded from the state.
- `fault` is decoded from the state.
- `imem_addr` is `iaddr`.

Other rules:
- `imem_ack` is ignored outside FETCH.
- `inst_ready` is ignored outside HOLD.

## Timing
Reset values (asynchronous on `rst_n` low):
- State IDLE; PC = `RESET_PC`, so `iaddr` = `imem_addr` = `RESET_PC`.
- `imem_req` = 0, `inst_valid` = 0, `inst` = 0.
- `fault` = 0, `fault_code` = 0, `retired` = 0, timeout counter = 0.

Latencies:
- The first `imem_req` is asserted in the cycle after the first rising edge with `rst_n` high.
- If `imem_ack` arrives in cycle N, `inst_valid` = 1 in cycle N+1.
- A consume on the edge ending cycle M puts the new PC and `imem_req` = 1 in cycle M+1.
- With zero-wait memory and `inst_ready` tied high, peak throughput is 1 instruction per 2 cycles.

Reset mid-operation:
- Asserting `rst_n` during FETCH drops `imem_req` immediately.
- The memory must tolerate an abandoned request.

## Test plan
1. Reset release with `imem_ack` tied 1, `imem_rdata` = 32'h2408_0005, `inst_ready` = 1, `niaddr` = `iaddr` + 4:
   - `iaddr` sequence is 3000, 3004, 3008.
   - `inst_valid` pulses every second cycle.
   - `retired` = 3 after 3 consumes.
2. Backpressure: hold `inst_ready` low for 5 cycles in HOLD.
   - `inst` is stable, `imem_req` = 0, `iaddr` is unchanged.
   - A consume on the 6th cycle loads `niaddr`.
3. Branch redirect: `niaddr` = 32'h0000_2FFC on a consume.
   - The next `imem_addr` is 32'h0000_2FFC.
4. Misaligned target: `niaddr` = 32'h0000_3006 on a consume.
   - FAULT is entered with `fault_code` = 01 and `iaddr` unchanged.
   - `retired` incremented.
   - `imem_req` stays 0 until reset.
5. Timeout:
   - `imem_ack` held 0 for 16 cycles gives `fault_code` = 10 on the 17th cycle.
   - A separate run with ack in exactly the 16th cycle reaches HOLD with no fault.
6. Reset mid-fetch:
   - Drop `rst_n` during FETCH; `imem_req` falls without waiting for a clock edge.
   - `iaddr` returns to `RESET_PC` and `retired` = 0.
   - Normal fetch resumes after release.

Source files
------------

// File: rtl/ifu.sv
// ifu: instruction fetch unit.
// Owns the architectural PC and fetches the word at PC over a req/ack
// handshake. It holds that word for decode with a valid/ready handshake
// and commits the next PC from npc when decode consumes the word.
// Misaligned next PCs and fetches that are never acknowledged put the unit
// into a sticky FAULT state. Only reset leaves that state.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    input  logic [31:0] niaddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        inst_ready,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    // TIMEOUT is at most 255, so the last tolerated count fits in 8 bits.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  tcnt;
    logic        consume;

    // These outputs are decoded from the state. As a result, an asynchronous
    // reset drops imem_req at once, without waiting for a clock edge.
    assign imem_req   = (state == FETCH);
    assign inst_valid = (state == HOLD);
    assign fault      = (state == FAULT);
    assign iaddr      = pc;
    assign imem_addr  = pc;
    assign consume    = inst_valid & inst_ready;

    // Fetch/hold/fault state machine with PC, instruction and retire registers.
    // NOTE: every register here uses non-blocking assignments. Each state
    // update therefore reads the values from before the edge, and the order
    // of the statements below does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            tcnt       <= '0;
            fault_code <= CODE_NONE;
            retired    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (imem_ack) begin
                        // On the last tolerated cycle the ack still takes
                        // priority over the timeout.
                        inst  <= imem_rdata;
                        tcnt  <= '0;
                        state <= HOLD;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt == TCNT_LAST) begin
                            fault_code <= CODE_TIMEOUT;
                            state      <= FAULT;
                        end
                    end
                end

                HOLD: begin
                    if (consume) begin
                        retired <= retired + 32'd1;
                        if (niaddr[1:0] == 2'b00) begin
                            pc    <= niaddr;
                            state <= FETCH;
                        end else begin
                            // Keep the PC of the instruction whose successor
                            // is misaligned, so the fault can be traced.
                            fault_code <= CODE_MISALIGN;
                            state      <= FAULT;
                        end
                    end
                end

                FAULT: begin
                    state <= FAULT;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed test of the instruction fetch unit.
// The bench drives inputs and samples outputs 1 ns after each rising edge.
// All expected values are constants worked out by hand from the protocol.
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] niaddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    // When use_inc is set, niaddr models sequential flow (iaddr + 4).
    // Otherwise it takes the forced target.
    logic        use_inc;
    logic [31:0] nia_forced;

    int vectors;
    int miscompares;

    assign niaddr = use_inc ? (iaddr + 32'd4) : nia_forced;

    ifu #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iaddr      (iaddr),
        .niaddr     (niaddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .fault      (fault),
        .fault_code (fault_code),
        .retired    (retired)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full reset pulse. Release happens on a falling edge, so the next rising
    // edge is the first edge with rst_n high.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        use_inc     = 1'b1;
        nia_forced  = 32'h0;

        // ---- Reset values ----
        #1 rst_n = 1'b0;
        #2;
        check("rst_iaddr",   iaddr,      32'h3000);
        check("rst_imaddr",  imem_addr,  32'h3000);
        check("rst_req",     {31'b0, imem_req},   32'd0);
        check("rst_valid",   {31'b0, inst_valid}, 32'd0);
        check("rst_inst",    inst,       32'd0);
        check("rst_fault",   {31'b0, fault},      32'd0);
        check("rst_code",    {30'b0, fault_code}, 32'd0);
        check("rst_retired", retired,    32'd0);

        // ---- 1: zero-wait streaming, sequential PCs ----
        imem_ack   = 1'b1;
        imem_rdata = 32'h2408_0005;
        inst_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();  // IDLE -> FETCH
        check("t1_req0",   {31'b0, imem_req}, 32'd1);
        check("t1_addr0",  imem_addr, 32'h3000);
        for (int k = 0; k < 3; k++) begin
            tick();  // FETCH -> HOLD
            check($sformatf("t1_valid%0d", k), {31'b0, inst_valid}, 32'd1);
            check($sformatf("t1_noreq%0d", k), {31'b0, imem_req},   32'd0);
            check($sformatf("t1_inst%0d", k),  inst, 32'h2408_0005);
            tick();  // consume: HOLD -> FETCH
            check($sformatf("t1_invalid%0d", k), {31'b0, inst_valid}, 32'd0);
            check($sformatf("t1_iaddr%0d", k),   iaddr, 32'h3000 + 32'(4 * (k + 1)));
            check($sformatf("t1_retired%0d", k), retired, 32'(k + 1));
        end
        // The unit is now in FETCH at 0x300C with retired = 3.

        // ---- 2: backpressure for 5 HOLD cycles ----
        inst_ready = 1'b0;
        tick();  // FETCH -> HOLD, captures 0x24080005
        imem_rdata = 32'hDEAD_BEEF;  // must not disturb the held word
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_valid%0d", k), {31'b0, inst_valid}, 32'd1);
            check($sformatf("t2_inst%0d", k),  inst, 32'h2408_0005);
            check($sformatf("t2_req%0d", k),   {31'b0, imem_req}, 32'd0);
            check($sformatf("t2_iaddr%0d", k), iaddr, 32'h300C);
            if (k < 4) tick();
        end
        use_inc    = 1'b0;
        nia_forced = 32'h0000_3100;
        inst_ready = 1'b1;
        tick();  // consume on the 6th cycle
        check("t2_newpc",   iaddr,   32'h3100);
        check("t2_req",     {31'b0, imem_req}, 32'd1);
        check("t2_retired", retired, 32'd4);

        // ---- 3: branch redirect to 0x2FFC ----
        tick();  // FETCH -> HOLD with 0xDEADBEEF
        check("t3_inst", inst, 32'hDEAD_BEEF);
        imem_ack   = 1'b0;
        nia_forced = 32'h0000_2FFC;
        tick();  // consume -> FETCH cycle 1 at 0x2FFC
        check("t3_imaddr",  imem_addr, 32'h2FFC);
        check("t3_req",     {31'b0, imem_req}, 32'd1);
        check("t3_retired", retired, 32'd5);

        // ---- 5b: ack arriving in exactly the 16th FETCH cycle ----
        for (int k = 0; k < 15; k++) tick();  // edges ending cycles 1..15, no ack
        check("t5b_req_pre",   {31'b0, imem_req}, 32'd1);
        check("t5b_fault_pre", {31'b0, fault},    32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();  // edge ending cycle 16 with ack
        check("t5b_valid", {31'b0, inst_valid}, 32'd1);
        check("t5b_fault", {31'b0, fault},      32'd0);
        check("t5b_inst",  inst, 32'h1111_2222);

        // ---- 4: misaligned target 0x3006 ----
        nia_forced = 32'h0000_3006;
        tick();  // consume -> FAULT
        check("t4_fault",   {31'b0, fault},      32'd1);
        check("t4_code",    {30'b0, fault_code}, 32'd1);
        check("t4_iaddr",   iaddr,   32'h2FFC);
        check("t4_retired", retired, 32'd6);
        check("t4_valid",   {31'b0, inst_valid}, 32'd0);
        for (int k = 0; k < 3; k++) tick();  // ack and ready high, still stuck
        check("t4_req_stuck",   {31'b0, imem_req},   32'd0);
        check("t4_code_stuck",  {30'b0, fault_code}, 32'd1);
        check("t4_iaddr_stuck", iaddr, 32'h2FFC);

        // ---- 6: reset in the middle of a fetch ----
        use_inc    = 1'b1;
        imem_rdata = 32'h2408_0005;
        do_reset();
        tick();  // IDLE -> FETCH 0x3000
        tick();  // -> HOLD
        tick();  // consume -> FETCH 0x3004, retired 1
        check("t6_pre_retired", retired, 32'd1);
        imem_ack = 1'b0;
        tick();
        check("t6_pre_req", {31'b0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;  // mid-cycle, away from any edge
        #1;
        check("t6_req_drop", {31'b0, imem_req}, 32'd0);
        check("t6_iaddr",    iaddr,   32'h3000);
        check("t6_retired",  retired, 32'd0);
        check("t6_fault",    {31'b0, fault}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_resume_req",  {31'b0, imem_req}, 32'd1);
        check("t6_resume_addr", imem_addr, 32'h3000);
        tick();
        check("t6_resume_valid", {31'b0, inst_valid}, 32'd1);

        // ---- 5a: 16 cycles without ack -> timeout fault ----
        imem_ack = 1'b0;
        do_reset();
        tick();  // IDLE -> FETCH cycle 1
        for (int k = 0; k < 15; k++) tick();
        check("t5a_req_16",   {31'b0, imem_req}, 32'd1);
        check("t5a_fault_16", {31'b0, fault},    32'd0);
        tick();  // edge ending cycle 16, no ack
        check("t5a_fault", {31'b0, fault},      32'd1);
        check("t5a_code",  {30'b0, fault_code}, 32'd2);
        check("t5a_req",   {31'b0, imem_req},   32'd0);
        check("t5a_iaddr", iaddr, 32'h3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
